vga_framebuffer: RTL and testbench
==================================

# vga_framebuffer

Pixel sink for the plot interface. Accepts single-cycle pixel writes (x, y, 3-bit color, plot strobe) from the sweep/plot generators into a 320×240×3-bit framebuffer. Scans that framebuffer out as 640×480@60 VGA timing, with each stored pixel doubled 2×2. It sits between the plotting logic and the board VGA DAC pins, on the same single clock, and the clock is the 25 MHz pixel clock.

## Interface
Parameters:
- XMAX, 319, last valid write x
- YMAX, 239, last valid write y
- H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in clocks
- V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines

Ports:
- clock  in  1  pixel clock; one clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- x  in  9  write column
- y  in  8  write row
- color  in  3  {r,g,b} write data
- plot  in  1  write strobe, one pixel per cycle while high
- clear  in  1  pulse: start filling the framebuffer with 0
- busy  out  1  high while a clear is in progress
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_blank  out  1  high outside the visible area
- vga_rgb  out  3  pixel color; forced 0 when blanked

## Operation
- Write port:
  - On a cycle with plot=1, busy=0, x≤XMAX and y≤YMAX, write color to addr = y*320 + x. Compute it as (y<<8)+(y<<6)+x, which is 17 bits.
  - Writes with out-of-range x or y are silently dropped.
  - plot is ignored while busy=1.
- Clear FSM with states IDLE and CLEAR:
  - IDLE→CLEAR on clear=1. In CLEAR, write 0 to clr_addr and increment it each cycle.
  - CLEAR→IDLE after the write to addr 76799, so a clear takes exactly 76800 cycles.
  - busy=1 exactly while in CLEAR.
  - clear asserted while already in CLEAR is ignored and does not restart the fill.
- Scan counters:
  - hcnt counts 0..799 and wraps to 0; vcnt increments when hcnt wraps and counts 0..524, then wraps to 0.
  - Visible region is hcnt<640 && vcnt<480.
  - Read address is (vcnt>>1)*320 + (hcnt>>1), used only when visible.
  - hsync is asserted for hcnt in [656,751].
  - vsync is asserted for vcnt in [490,491].
- RAM:
  - Simple dual-port: one write port and one synchronous read port.
  - On a same-address read and write in the same cycle, the read returns the old data (read-first).
  - Reset does not clear RAM contents; only clear does.
- Reset:
  - hcnt=0, vcnt=0, FSM=IDLE, clr_addr=0.
  - Output reset values: vga_hs=1, vga_vs=1, vga_blank=1, vga_rgb=0, busy=0.
  - A reset asserted mid-clear aborts the clear, leaving the RAM partially cleared, and busy=0 on the next cycle.

## Timing
- Scan pipeline is 2 stages:
  - Stage 1 registers the read address and delays visible/hs/vs by one.
  - Stage 2 is RAM data out, with visible/hs/vs delayed one more stage.
- All four outputs (vga_hs, vga_vs, vga_blank, vga_rgb) therefore align and lag the counters by exactly 2 clocks.
  - The first visible pixel appears on vga_rgb 2 cycles after hcnt=vcnt=0.
- Write-to-display latency: a pixel written in cycle N is readable by any scan read issued in cycle N+1 or later.
- Frame period is 800×525 = 420000 clocks.
- busy rises the cycle after clear is sampled and falls the cycle after the last clear write.

## Structure
- Shared package holds:
  - the timing parameter defaults,
  - the FB_W=320, FB_H=240 and FB_DEPTH=76800 constants,
  - the 17-bit address width,
  - the clear FSM state encoding.
- One sub-module, fb_ram: 76800×3 simple dual-port, read-first, synchronous read. It is written so it infers block RAM.
- Counters, clear FSM, write muxing and the output pipeline live in the top module.

## Test plan
- Reset: hold reset 5 cycles. Required: vga_hs=1, vga_vs=1, vga_blank=1, vga_rgb=0, busy=0. After release, first hs low occurs 656+2 cycles later, and hs is low for exactly 96 cycles.
- Frame timing: run 2 frames. Required: hs period 800, vs low for 2 lines (1600 clocks) starting at line 490, frame period 420000, blank high for hcnt≥640 or vcnt≥480 (after the 2-cycle lag).
- Write/readback:
  - Plot (0,0)=3'b101 and (319,239)=3'b010.
  - Screen pixels (0..1,0..1) must show 101 and (638..639,478..479) must show 010; all other pixels show 0.
- Out-of-range write: plot x=320,y=0 and x=0,y=240 with color 7. Required: the framebuffer is unchanged, and no pixel shows 7.
- Clear:
  - Fill RAM with 7, then pulse clear.
  - busy must be high for exactly 76800 cycles and plot writes during that time must be ignored.
  - The next full frame must be all 0.
  - A second clear pulse mid-fill must not extend busy.
- Reset mid-clear: assert reset 1000 cycles into a clear. Required: busy=0 next cycle. Addresses 0..999 read 0 and address 1000 onward retain their prior values.

Source files
------------

// File: rtl/vga_framebuffer_pkg.sv
// Shared constants, clear FSM encoding and pixel address helper for the VGA framebuffer.
package vga_framebuffer_pkg;

  localparam int DEF_XMAX   = 319;
  localparam int DEF_YMAX   = 239;
  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam int FB_W     = 320;
  localparam int FB_H     = 240;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int ADDR_W   = 17;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // y*320 + x built from shifts so no multiplier is needed.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [8:0] px, input logic [7:0] py);
    logic [ADDR_W-1:0] yy;
    yy = {9'd0, py};
    return (yy << 8) + (yy << 6) + {8'd0, px};
  endfunction

endpackage

// File: rtl/vga_framebuffer_if.sv
// Plot bus between the sweep/plot generators and the framebuffer.
interface vga_framebuffer_if;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] color;
  logic       plot;
  logic       clear;
  logic       busy;

  modport master (output x, y, color, plot, clear, input busy);
  modport slave  (input x, y, color, plot, clear, output busy);
endinterface

// File: rtl/vga_framebuffer_fb_ram.sv
// 76800 x 3 simple dual-port RAM, synchronous read-first, shaped for block RAM inference.
module fb_ram
  import vga_framebuffer_pkg::*;
(
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [2:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [2:0]        rdata
);

  logic [2:0] mem [FB_DEPTH];

  // Write and registered read share one process, so a same-address read sees the old word.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_framebuffer.sv
// Framebuffer top: plot writes, clear fill, 640x480 scan with 2x2 pixel doubling.
module vga_framebuffer
  import vga_framebuffer_pkg::*;
#(
  parameter int XMAX   = DEF_XMAX,
  parameter int YMAX   = DEF_YMAX,
  parameter int H_VIS  = DEF_H_VIS,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_VIS  = DEF_V_VIS,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP
) (
  input  logic              clock,
  input  logic              reset,
  vga_framebuffer_if.slave  pix,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank,
  output logic [2:0]        vga_rgb
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  // Clear covers every writable row; with default geometry this is address 76799.
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'((YMAX + 1) * FB_W - 1);

  logic [9:0]        hcnt, vcnt;
  clr_state_t        state, state_next;
  logic [ADDR_W-1:0] clr_addr, clr_next;
  logic              we;
  logic [ADDR_W-1:0] waddr, scan_addr, rd_addr;
  logic [2:0]        wdata, rdata;
  logic              visible, hs_on, vs_on;
  logic              vis1, hs1, vs1, vis2, hs2, vs2;

  // Horizontal and vertical scan counters; vertical steps when the line wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == 10'(H_TOTAL - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == 10'(V_TOTAL - 1)) ? 10'd0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  // Decode the visible window and sync pulses, and form the doubled-pixel read address.
  always_comb begin
    visible   = (hcnt < 10'(H_VIS)) && (vcnt < 10'(V_VIS));
    hs_on     = (hcnt >= 10'(H_VIS + H_FP)) && (hcnt < 10'(H_VIS + H_FP + H_SYNC));
    vs_on     = (vcnt >= 10'(V_VIS + V_FP)) && (vcnt < 10'(V_VIS + V_FP + V_SYNC));
    scan_addr = '0;
    if (visible) scan_addr = pixel_addr(9'(hcnt >> 1), 8'(vcnt >> 1));
  end

  // Clear FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      clr_addr <= '0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_next;
    end
  end

  // Clear FSM next state: walk clr_addr once through the writable rows; re-triggers are ignored.
  always_comb begin
    state_next = state;
    clr_next   = clr_addr;
    case (state)
      IDLE: begin
        if (pix.clear) begin
          state_next = CLEAR;
          clr_next   = '0;
        end
      end
      CLEAR: begin
        clr_next = clr_addr + ADDR_W'(1);
        if (clr_addr == CLR_LAST) begin
          state_next = IDLE;
          clr_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pix.busy = (state == CLEAR);

  // Write mux: the clear fill owns the port while busy; reset blocks writes so an aborted clear stops cleanly.
  always_comb begin
    we    = 1'b0;
    waddr = pixel_addr(pix.x, pix.y);
    wdata = pix.color;
    if (state == CLEAR) begin
      we    = !reset;
      waddr = clr_addr;
      wdata = 3'b000;
    end else if (pix.plot && !reset && (pix.x <= 9'(XMAX)) && (pix.y <= 8'(YMAX))) begin
      we = 1'b1;
    end
  end

  fb_ram u_ram (
    .clock (clock),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rdata)
  );

  // Two-stage scan pipeline keeping sync/blank aligned with RAM read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_addr <= '0;
      vis1    <= 1'b0;
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      vis2    <= 1'b0;
      hs2     <= 1'b0;
      vs2     <= 1'b0;
    end else begin
      rd_addr <= scan_addr;
      vis1    <= visible;
      hs1     <= hs_on;
      vs1     <= vs_on;
      vis2    <= vis1;
      hs2     <= hs1;
      vs2     <= vs1;
    end
  end

  assign vga_hs    = !hs2;
  assign vga_vs    = !vs2;
  assign vga_blank = !vis2;
  assign vga_rgb   = vis2 ? rdata : 3'b000;

endmodule

// File: tb/tb_vga_framebuffer.sv
// Self-checking bench for vga_framebuffer using a reduced screen geometry and a pixel-array model.
module tb_vga_framebuffer;
  import vga_framebuffer_pkg::*;

  localparam int XMAX   = 31;
  localparam int YMAX   = 15;
  localparam int H_VIS  = 64;
  localparam int H_FP   = 4;
  localparam int H_SYNC = 8;
  localparam int H_BP   = 4;
  localparam int V_VIS  = 32;
  localparam int V_FP   = 2;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 3;
  localparam int HT     = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT     = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME  = HT * VT;
  localparam int CLR_DEPTH = (YMAX + 1) * FB_W;

  logic       clock;
  logic       reset;
  logic       vga_hs, vga_vs, vga_blank;
  logic [2:0] vga_rgb;
  int         n_cmp;
  int         n_bad;
  longint     cyc;
  logic [2:0] model [FB_DEPTH];

  vga_framebuffer_if pif ();

  vga_framebuffer #(
    .XMAX(XMAX), .YMAX(YMAX),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pix       (pif),
    .vga_hs    (vga_hs),
    .vga_vs    (vga_vs),
    .vga_blank (vga_blank),
    .vga_rgb   (vga_rgb)
  );

  initial clock = 1'b0;
  always #20 clock = ~clock;

  // Clocks elapsed since reset was last released.
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Expected {hs, vs, blank, rgb} for the sample taken n clocks after reset release.
  function automatic logic [5:0] exp_out(input longint n);
    longint     p;
    int         h, v;
    logic       vis;
    logic [2:0] c;
    if (n < 2) return 6'b111000;
    p   = (n - 2) % FRAME;
    h   = int'(p % HT);
    v   = int'(p / HT);
    vis = (h < H_VIS) && (v < V_VIS);
    c   = vis ? model[(v / 2) * FB_W + h / 2] : 3'd0;
    return {!(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC),
            !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC),
            !vis, c};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    pif.plot  = 1'b0;
    pif.clear = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic plot_px(input int x, input int y, input logic [2:0] c);
    pif.x     = 9'(x);
    pif.y     = 8'(y);
    pif.color = c;
    pif.plot  = 1'b1;
    tick();
    if (x <= XMAX && y <= YMAX) model[y * FB_W + x] = c;
  endtask

  task automatic fill_all(input bit rnd);
    for (int y = 0; y <= YMAX; y++)
      for (int x = 0; x <= XMAX; x++)
        plot_px(x, y, rnd ? 3'($urandom_range(1, 6)) : 3'd7);
    idle(3);
  endtask

  task automatic test_reset();
    int first, low;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({vga_hs, vga_vs, vga_blank, vga_rgb, pif.busy} !== 7'b1110000) begin
        n_bad++;
        $display("[TB] FAIL reset_outputs: got %b expected 1110000",
                 {vga_hs, vga_vs, vga_blank, vga_rgb, pif.busy});
      end
    end
    reset = 1'b0;
    first = -1;
    for (int n = 1; n <= HT + 10; n++) begin
      tick();
      if (vga_hs === 1'b0) begin
        first = n;
        break;
      end
    end
    n_cmp++;
    if (first != H_VIS + H_FP + 2) begin
      n_bad++;
      $display("[TB] FAIL first_hs_low: got %0d expected %0d", first, H_VIS + H_FP + 2);
    end
    low = 0;
    while (vga_hs === 1'b0 && low < HT + 5) begin
      low++;
      tick();
    end
    n_cmp++;
    if (low != H_SYNC) begin
      n_bad++;
      $display("[TB] FAIL hs_width: got %0d expected %0d", low, H_SYNC);
    end
  endtask

  task automatic test_frame_timing();
    logic [5:0] e;
    logic       prev_hs, prev_vs;
    longint     hs_fall, vs_fall;
    int         vs_falls;
    prev_hs = vga_hs; prev_vs = vga_vs;
    hs_fall = -1; vs_fall = -1; vs_falls = 0;
    for (int i = 0; i < 2 * FRAME + 2 * HT; i++) begin
      tick();
      e = exp_out(cyc);
      n_cmp++;
      if ({vga_hs, vga_vs, vga_blank} !== e[5:3] || (e[3] && vga_rgb !== 3'd0)) begin
        n_bad++;
        $display("[TB] FAIL timing cyc=%0d: got %b%b%b rgb=%0d expected %b rgb=0 when blank",
                 cyc, vga_hs, vga_vs, vga_blank, vga_rgb, e[5:3]);
      end
      if (prev_hs && !vga_hs) begin
        if (hs_fall >= 0) begin
          n_cmp++;
          if (cyc - hs_fall != HT) begin
            n_bad++;
            $display("[TB] FAIL hs_period: got %0d expected %0d", cyc - hs_fall, HT);
          end
        end
        hs_fall = cyc;
      end
      if (prev_vs && !vga_vs) begin
        n_cmp++;
        if ((cyc - 2) % FRAME != (V_VIS + V_FP) * HT) begin
          n_bad++;
          $display("[TB] FAIL vs_start: got %0d expected %0d", (cyc - 2) % FRAME, (V_VIS + V_FP) * HT);
        end
        if (vs_fall >= 0) begin
          n_cmp++;
          if (cyc - vs_fall != FRAME) begin
            n_bad++;
            $display("[TB] FAIL frame_period: got %0d expected %0d", cyc - vs_fall, FRAME);
          end
        end
        vs_fall = cyc;
        vs_falls++;
      end
      if (!prev_vs && vga_vs && vs_fall >= 0) begin
        n_cmp++;
        if (cyc - vs_fall != V_SYNC * HT) begin
          n_bad++;
          $display("[TB] FAIL vs_width: got %0d expected %0d", cyc - vs_fall, V_SYNC * HT);
        end
      end
      prev_hs = vga_hs;
      prev_vs = vga_vs;
    end
    n_cmp++;
    if (vs_falls < 2) begin
      n_bad++;
      $display("[TB] FAIL vs_count: got %0d expected at least 2", vs_falls);
    end
  endtask

  task automatic test_clear();
    int         bcount;
    logic [5:0] e;
    fill_all(1'b0);
    pif.clear = 1'b1;
    tick();
    pif.clear = 1'b0;
    n_cmp++;
    if (pif.busy !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL busy_rise: got %b expected 1", pif.busy);
    end
    bcount = 0;
    while (pif.busy === 1'b1 && bcount < CLR_DEPTH + 100) begin
      bcount++;
      pif.x     = 9'($urandom_range(0, XMAX));
      pif.y     = 8'($urandom_range(0, YMAX));
      pif.color = 3'($urandom_range(1, 7));
      pif.plot  = 1'b1;
      pif.clear = (bcount == 200);
      tick();
    end
    pif.plot  = 1'b0;
    pif.clear = 1'b0;
    n_cmp++;
    if (bcount != CLR_DEPTH) begin
      n_bad++;
      $display("[TB] FAIL busy_length: got %0d expected %0d", bcount, CLR_DEPTH);
    end
    for (int a = 0; a < CLR_DEPTH; a++) model[a] = 3'd0;
    idle(3);
    for (int i = 0; i < FRAME; i++) begin
      tick();
      e = exp_out(cyc);
      n_cmp++;
      if ({vga_hs, vga_vs, vga_blank, vga_rgb} !== e) begin
        n_bad++;
        $display("[TB] FAIL scan_after_clear cyc=%0d: got %b expected %b",
                 cyc, {vga_hs, vga_vs, vga_blank, vga_rgb}, e);
      end
    end
  endtask

  task automatic test_write_readback();
    logic [5:0] e;
    plot_px(0, 0, 3'b101);
    plot_px(XMAX, YMAX, 3'b010);
    idle(3);
    for (int i = 0; i < FRAME; i++) begin
      tick();
      e = exp_out(cyc);
      n_cmp++;
      if ({vga_hs, vga_vs, vga_blank, vga_rgb} !== e) begin
        n_bad++;
        $display("[TB] FAIL scan_corners cyc=%0d: got %b expected %b",
                 cyc, {vga_hs, vga_vs, vga_blank, vga_rgb}, e);
      end
    end
    for (int k = 0; k < 60; k++)
      plot_px($urandom_range(0, XMAX), $urandom_range(0, YMAX), 3'($urandom_range(0, 6)));
    idle(3);
    for (int i = 0; i < FRAME; i++) begin
      tick();
      e = exp_out(cyc);
      n_cmp++;
      if ({vga_hs, vga_vs, vga_blank, vga_rgb} !== e) begin
        n_bad++;
        $display("[TB] FAIL scan_random cyc=%0d: got %b expected %b",
                 cyc, {vga_hs, vga_vs, vga_blank, vga_rgb}, e);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [5:0] e;
    int         sevens;
    plot_px(XMAX + 1, 0, 3'd7);
    plot_px(0, YMAX + 1, 3'd7);
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 0) plot_px($urandom_range(XMAX + 1, 511), $urandom_range(0, 255), 3'd7);
      else                           plot_px($urandom_range(0, 511), $urandom_range(YMAX + 1, 255), 3'd7);
    end
    idle(3);
    sevens = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      e = exp_out(cyc);
      if (vga_rgb === 3'd7) sevens++;
      n_cmp++;
      if ({vga_hs, vga_vs, vga_blank, vga_rgb} !== e) begin
        n_bad++;
        $display("[TB] FAIL scan_oor cyc=%0d: got %b expected %b",
                 cyc, {vga_hs, vga_vs, vga_blank, vga_rgb}, e);
      end
    end
    n_cmp++;
    if (sevens != 0) begin
      n_bad++;
      $display("[TB] FAIL oor_sevens: got %0d expected 0", sevens);
    end
  endtask

  task automatic test_reset_mid_clear();
    int         bcount, guard;
    logic [5:0] e;
    fill_all(1'b1);
    pif.clear = 1'b1;
    tick();
    pif.clear = 1'b0;
    bcount = 0;
    guard  = 0;
    while (guard < 2000) begin
      if (pif.busy === 1'b1) bcount++;
      if (bcount == 1001) break;
      tick();
      guard++;
    end
    n_cmp++;
    if (bcount != 1001) begin
      n_bad++;
      $display("[TB] FAIL midclear_busy_count: got %0d expected 1001", bcount);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (pif.busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL midclear_busy_drop: got %b expected 0", pif.busy);
    end
    reset = 1'b0;
    for (int a = 0; a < 1000; a++) model[a] = 3'd0;
    for (int i = 0; i < FRAME + 2; i++) begin
      tick();
      e = exp_out(cyc);
      n_cmp++;
      if ({vga_hs, vga_vs, vga_blank, vga_rgb} !== e) begin
        n_bad++;
        $display("[TB] FAIL scan_midclear cyc=%0d: got %b expected %b",
                 cyc, {vga_hs, vga_vs, vga_blank, vga_rgb}, e);
      end
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    pif.x     = '0;
    pif.y     = '0;
    pif.color = '0;
    pif.plot  = 1'b0;
    pif.clear = 1'b0;
    for (int a = 0; a < FB_DEPTH; a++) model[a] = 3'd0;
    $display("[TB] starting vga_framebuffer bench");
    test_reset();
    test_frame_timing();
    test_clear();
    test_write_readback();
    test_out_of_range();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
